// File: rtl/bus_xcvr_sched_if.sv
// Request/acknowledge and transceiver-control signals for bus_xcvr_sched.
// The slave modport is the scheduler's view; master is the requesters' and transceivers' view.
interface bus_xcvr_sched_if;
    logic req0;
    logic wr0;
    logic ack0;
    logic req1;
    logic wr1;
    logic ack1;
    logic xcvr_dr;
    logic xcvr_cs_n;
    logic owner;
    logic busy;

    modport master (
        output req0, wr0, req1, wr1,
        input  ack0, ack1, xcvr_dr, xcvr_cs_n, owner, busy
    );

    modport slave (
        input  req0, wr0, req1, wr1,
        output ack0, ack1, xcvr_dr, xcvr_cs_n, owner, busy
    );
endinterface

// File: rtl/bus_xcvr_sched.sv
// Two-port arbiter/sequencer for a shared 74LS245-style transceiver pair. Inserts dead cycles
// around every transfer and direction reversal so the A and B sides never fight.
module bus_xcvr_sched #(
    parameter int unsigned TURN_CYCLES = 1,
    parameter int unsigned HOLD_CYCLES = 2
) (
    input  logic            clk,
    input  logic            reset,
    bus_xcvr_sched_if.slave bus
);
    localparam int unsigned CntMax = (TURN_CYCLES > HOLD_CYCLES) ? TURN_CYCLES : HOLD_CYCLES;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    typedef enum logic [1:0] {StIdle, StTurn, StActive, StRecover} state_e;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic            cs_n_q;
    logic            dr_q;
    logic            ack0_q;
    logic            ack1_q;
    logic            owner_q;
    logic            busy_q;

    logic winner;
    logic win_wr;
    logic req_own;

    // Round-robin: on a tie the port that was not last granted wins.
    always_comb begin
        winner = 1'b0;
        if (bus.req0 && bus.req1) begin
            winner = ~owner_q;
        end else if (bus.req1) begin
            winner = 1'b1;
        end
        win_wr  = winner ? bus.wr1 : bus.wr0;
        req_own = owner_q ? bus.req1 : bus.req0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            cs_n_q  <= 1'b1;
            dr_q    <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            owner_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    cs_n_q <= 1'b1;
                    if (bus.req0 || bus.req1) begin
                        owner_q <= winner;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        if (win_wr == dr_q) begin
                            state_q <= StActive;
                            cs_n_q  <= 1'b0;
                            ack0_q  <= (HOLD_CYCLES == 1) && !winner;
                            ack1_q  <= (HOLD_CYCLES == 1) && winner;
                        end else begin
                            // Direction only ever changes here, with cs_n already high.
                            dr_q    <= win_wr;
                            state_q <= StTurn;
                        end
                    end
                end
                StTurn: begin
                    if (!req_own) begin
                        state_q <= StRecover;
                    end else if (cnt_q == CntW'(TURN_CYCLES - 1)) begin
                        state_q <= StActive;
                        cnt_q   <= '0;
                        cs_n_q  <= 1'b0;
                        ack0_q  <= (HOLD_CYCLES == 1) && !owner_q;
                        ack1_q  <= (HOLD_CYCLES == 1) && owner_q;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StActive: begin
                    if (!req_own || cnt_q == CntW'(HOLD_CYCLES - 1)) begin
                        // Either the hold time is done or the owner withdrew: disable, no ack.
                        state_q <= StRecover;
                        cs_n_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                        if (cnt_q + CntW'(1) == CntW'(HOLD_CYCLES - 1)) begin
                            ack0_q <= !owner_q;
                            ack1_q <= owner_q;
                        end
                    end
                end
                StRecover: begin
                    state_q <= StIdle;
                    cs_n_q  <= 1'b1;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    cs_n_q  <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.xcvr_cs_n = cs_n_q;
    assign bus.xcvr_dr   = dr_q;
    assign bus.ack0      = ack0_q;
    assign bus.ack1      = ack1_q;
    assign bus.owner     = owner_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_bus_xcvr_sched.sv
// Directed checks of bus_xcvr_sched with default timing, plus a randomised turnaround-gap
// run on a second instance built with TURN_CYCLES=3.
module tb_bus_xcvr_sched;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    bus_xcvr_sched_if bus ();
    bus_xcvr_sched_if bus2 ();

    bus_xcvr_sched #(.TURN_CYCLES(1), .HOLD_CYCLES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    bus_xcvr_sched #(.TURN_CYCLES(3), .HOLD_CYCLES(2)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Compare the five main outputs of the default instance at once.
    task automatic check_outs(input string tag, input logic cs_n, input logic dr,
                              input logic a0, input logic a1, input logic bsy);
        check_eq({tag, ".cs_n"}, 32'(bus.xcvr_cs_n), 32'(cs_n));
        check_eq({tag, ".dr"},   32'(bus.xcvr_dr),   32'(dr));
        check_eq({tag, ".ack0"}, 32'(bus.ack0),      32'(a0));
        check_eq({tag, ".ack1"}, 32'(bus.ack1),      32'(a1));
        check_eq({tag, ".busy"}, 32'(bus.busy),      32'(bsy));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.req0 = 1'b0; bus.wr0 = 1'b0; bus.req1 = 1'b0; bus.wr1 = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
    endtask

    int   ack_cyc[8];
    int   ack_port[8];
    int   n_ack;
    logic prev_dr;
    logic prev_cs;
    int   gap;
    logic turn_pend;
    int   n_xfer;
    int   n_p0;
    int   n_p1;
    int   n_turns;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        bus2.req0 = 1'b0; bus2.wr0 = 1'b0; bus2.req1 = 1'b0; bus2.wr1 = 1'b0;

        // Reset state
        reset = 1'b1;
        bus.req0 = 1'b0; bus.wr0 = 1'b0; bus.req1 = 1'b0; bus.wr1 = 1'b0;
        repeat (2) tick();
        check_outs("reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("reset.owner", 32'(bus.owner), 32'd1);

        // Same-direction read on port 0: no turnaround
        reset = 1'b0; bus.req0 = 1'b1; bus.wr0 = 1'b0;
        tick();
        check_outs("rd.E", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("rd.owner", 32'(bus.owner), 32'd0);
        tick();
        check_outs("rd.E1", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        bus.req0 = 1'b0;
        tick();
        check_outs("rd.recover", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        check_outs("rd.idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Write on port 0 after reset: dr flips with cs_n high, then two enabled cycles
        do_reset();
        bus.req0 = 1'b1; bus.wr0 = 1'b1;
        tick();
        check_outs("wr.E", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        check_outs("wr.E1", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        check_outs("wr.E2", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        bus.req0 = 1'b0;
        tick();
        check_outs("wr.recover", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);

        // Both ports held: grants alternate 0,1,0,1 four cycles apart
        do_reset();
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        n_ack = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            check_eq("rr.no_double_ack", 32'(bus.ack0 & bus.ack1), 32'd0);
            if ((bus.ack0 || bus.ack1) && n_ack < 8) begin
                ack_cyc[n_ack]  = c;
                ack_port[n_ack] = bus.ack1 ? 1 : 0;
                n_ack++;
            end
        end
        check_eq("rr.n_ack", 32'(n_ack), 32'd5);
        check_eq("rr.first_cyc", 32'(ack_cyc[0]), 32'd1);
        for (int i = 0; i < 4; i++) begin
            check_eq("rr.port", 32'(ack_port[i]), 32'(i % 2));
            if (i > 0) check_eq("rr.spacing", 32'(ack_cyc[i] - ack_cyc[i-1]), 32'd4);
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;

        // Port 1 withdraws in its first ACTIVE cycle; pending port 0 then served normally
        do_reset();
        bus.req1 = 1'b1; bus.wr1 = 1'b0;
        tick();
        check_outs("abort.E", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("abort.owner", 32'(bus.owner), 32'd1);
        bus.req1 = 1'b0; bus.req0 = 1'b1; bus.wr0 = 1'b0;
        tick();
        check_outs("abort.recover", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        check_outs("abort.idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check_outs("abort.p0_E", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("abort.p0_owner", 32'(bus.owner), 32'd0);
        tick();
        check_outs("abort.p0_ack", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        bus.req0 = 1'b0;

        // Reset during the final ACTIVE cycle of a write
        do_reset();
        bus.req0 = 1'b1; bus.wr0 = 1'b1;
        repeat (3) tick();
        check_outs("rst_mid.final", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        reset = 1'b1;
        tick();
        check_outs("rst_mid.after", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("rst_mid.owner", 32'(bus.owner), 32'd1);
        bus.req0 = 1'b0;
        reset = 1'b0;

        // Random mixed-direction traffic on the TURN_CYCLES=3 instance
        do_reset();
        prev_dr = bus2.xcvr_dr;
        prev_cs = bus2.xcvr_cs_n;
        gap = 0; turn_pend = 1'b0;
        n_xfer = 0; n_p0 = 0; n_p1 = 0; n_turns = 0;
        for (int c = 0; c < 5000 && n_xfer < 100; c++) begin
            tick();
            if (bus2.xcvr_dr != prev_dr) begin
                check_eq("rand.dr_edge_cs", 32'({prev_cs, bus2.xcvr_cs_n}), 32'b11);
                gap = bus2.xcvr_cs_n ? 1 : 0;
                turn_pend = 1'b1;
                n_turns++;
            end else if (bus2.xcvr_cs_n) begin
                gap++;
            end
            if (prev_cs && !bus2.xcvr_cs_n && turn_pend) begin
                check_eq("rand.turn_gap", 32'(gap >= 3), 32'd1);
                turn_pend = 1'b0;
            end
            prev_dr = bus2.xcvr_dr;
            prev_cs = bus2.xcvr_cs_n;
            if (bus2.ack0) begin
                check_eq("rand.ack0_req", 32'(bus2.req0), 32'd1);
                bus2.req0 = 1'b0; n_xfer++; n_p0++;
            end else if (!bus2.req0 && $urandom_range(2) == 0) begin
                bus2.req0 = 1'b1; bus2.wr0 = 1'($urandom_range(1));
            end
            if (bus2.ack1) begin
                check_eq("rand.ack1_req", 32'(bus2.req1), 32'd1);
                bus2.req1 = 1'b0; n_xfer++; n_p1++;
            end else if (!bus2.req1 && $urandom_range(2) == 0) begin
                bus2.req1 = 1'b1; bus2.wr1 = 1'($urandom_range(1));
            end
        end
        check_eq("rand.done", 32'(n_xfer >= 100), 32'd1);
        check_eq("rand.p0_served", 32'(n_p0 > 20), 32'd1);
        check_eq("rand.p1_served", 32'(n_p1 > 20), 32'd1);
        check_eq("rand.turns_seen", 32'(n_turns > 10), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
